prefix_adder_pipe: RTL and testbench
====================================

Name: prefix_adder_pipe

Overview:
Parametrised pipelined parallel-prefix adder/subtractor and the successor to prefix_tree. It generalises prefix_tree with a selectable prefix topology, configurable register spacing between prefix levels, carry-in, subtract mode and ready/valid backpressure. It sits in the Clever-Adders datapath as the reusable N-bit add/sub unit and produces sum, carry-out and signed overflow.

Parameters:
N, 32, operand width in bits; must be >= 2.
TOPO, 0, prefix topology: 0 = Kogge-Stone, 1 = Sklansky; any other value is an elaboration error.
REG_EVERY, 1, a pipeline register bank is placed after every REG_EVERY prefix levels; must be >= 1.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block accepts a beat when in_valid && in_ready.
a  in  N  operand A.
b  in  N  operand B.
cin  in  1  carry-in.
sub  in  1  1 = subtract (A + ~B + (cin^1)).
sum  out  N  result.
cout  out  1  carry-out of the MSB; in subtract mode, 1 means no borrow.
ovf  out  1  two's-complement overflow.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts the result.

Behaviour:
- LOG = $clog2(N); PB = ceil(LOG/REG_EVERY); latency LAT = 2 + PB cycles from the accept edge to out_valid, with no stall.
- Stage 0 (registered): b_eff = sub ? ~b : b; g = a & b_eff; p = a ^ b_eff; c0 = cin ^ sub. Also stores the MSBs of a and b_eff for overflow.
- Prefix levels 1..LOG use operator (g,p)o(g',p') = (g | p&g', p&p').
  - Kogge-Stone: at level k, bit i combines with i-2^(k-1) when i >= 2^(k-1).
  - Sklansky: at level k, bit i combines with bit ((i>>k)<<k) + 2^(k-1) - 1 when bit k-1 of i is set.
  - c0 is folded in as bit -1: g[0] |= p[0]&c0 before level 1.
- A register bank follows every REG_EVERY-th level and always follows level LOG. Valid and p travel with each bank.
- Final stage (registered): carry[i] = G[i-1] (carry[0] = c0); sum = p ^ carry; cout = G[N-1]; ovf = carry[N-1] ^ cout.
- Backpressure is a global stall: en = !(out_valid && !out_ready); in_ready = en. When en = 0 every pipeline register, including the valid bits, holds its value.
- Bubbles are not collapsed. in_ready is combinational from out_valid/out_ready only, never from in_valid.
- Ordering is strictly FIFO. Every accepted beat produces exactly one output beat; nothing is dropped or duplicated.
- When out_valid = 1 and out_ready = 0, sum/cout/ovf stay stable until the handshake completes.
- Reset:
  - Every valid bit clears, so out_valid = 0 from the cycle after the rst edge.
  - sum, cout and ovf reset to 0.
  - Data registers other than the outputs need no reset.
  - Reset mid-flight discards all in-flight beats, and no stale result ever appears.
  - While rst = 1, in_ready = 1 is permitted, but beats presented during rst are ignored.
- in_valid = 0 inserts a bubble. in_valid && !in_ready means the beat is not taken and the source must hold it.

Decomposition:
- Package adder_pkg holds:
  - typedef enum topo_e {TOPO_KS, TOPO_SK};
  - a parametrised gp pair struct;
  - function gp_combine(hi, lo);
  - function sk_partner(i, k) for Sklansky indexing;
  - function pipe_latency(N, REG_EVERY).
- Sub-module prefix_level #(N, LEVEL, TOPO): one combinational prefix level (g,p in -> g,p out). It is instantiated LOG times in a generate loop, with registers inserted by the parent.

Test Plan:
- N=16, REG_EVERY=1: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0; out_valid exactly 6 cycles after accept.
- N=16: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- N=16, sub=1: a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. a=0x0007, b=0x0005, cin=1 -> sum=0x0001, cout=1.
- Stream of 20 back-to-back beats with out_ready held low for 3 cycles mid-stream:
  - in_ready = 0 during the stall;
  - outputs stay stable during the stall;
  - all 20 results are correct and in order, with none lost or duplicated.
- Assert rst while 4 beats are in flight -> out_valid = 0 on the next cycle. After release, new beat 0x1234 + 0x1111 -> single result 0x2345, and no stale beats appear.
- Sweep N={8,16,32,64} x TOPO={0,1} x REG_EVERY={1,2,4} with 1000 random a/b/cin/sub beats and random out_ready:
  - results match a reference model;
  - latency equals 2 + ceil(log2N/REG_EVERY), e.g. N=16: 6/4/3.

Source files
------------

// File: rtl/prefix_adder_pipe_pkg.sv
// Shared types and helpers for the pipelined parallel-prefix adder.
package adder_pkg;

  typedef enum logic [0:0] {
    TOPO_KS = 1'b0,
    TOPO_SK = 1'b1
  } topo_e;

  // One bit position's generate/propagate pair; vectors of these form the prefix tree.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Prefix operator: hi is the more significant span, lo the span just below it.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Sklansky level k: bit i takes the top bit of the lower half of its 2^k block.
  function automatic int sk_partner(input int i, input int k);
    return ((i >> k) << k) + (1 << (k - 1)) - 1;
  endfunction

  // Cycles from the accept edge to out_valid with no stall.
  function automatic int pipe_latency(input int n, input int reg_every);
    int lg;
    lg = $clog2(n);
    return 2 + (lg + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/prefix_adder_pipe_if.sv
// Beat interface of the add/sub unit: one operand channel in, one result channel out.
// Handshake: a beat moves on a rising clk edge where valid && ready are both high;
// the sender keeps valid and payload unchanged until that edge, and ready never
// depends combinationally on the same channel's valid.
interface prefix_adder_pipe_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, sum, cout, ovf, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/prefix_adder_pipe_level.sv
// One combinational prefix level of the carry tree (Kogge-Stone or Sklansky wiring).
module prefix_level
  import adder_pkg::*;
#(
  parameter int N     = 32,
  parameter int LEVEL = 1,
  parameter int TOPO  = 0
) (
  input  gp_t [N-1:0] i_gp,
  output gp_t [N-1:0] o_gp
);

  localparam int DIST = 1 << (LEVEL - 1);

  for (genvar i = 0; i < N; i++) begin : g_bit
    if (TOPO == int'(TOPO_KS)) begin : g_ks
      if (i >= DIST) begin : g_comb
        assign o_gp[i] = gp_combine(i_gp[i], i_gp[i - DIST]);
      end else begin : g_pass
        assign o_gp[i] = i_gp[i];
      end
    end else begin : g_sk
      if (((i >> (LEVEL - 1)) & 1) == 1) begin : g_comb
        localparam int J = sk_partner(i, LEVEL);
        assign o_gp[i] = gp_combine(i_gp[i], i_gp[J]);
      end else begin : g_pass
        assign o_gp[i] = i_gp[i];
      end
    end
  end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined N-bit parallel-prefix adder/subtractor with a global-stall handshake.
module prefix_adder_pipe
  import adder_pkg::*;
#(
  parameter int N         = 32,
  parameter int TOPO      = 0,
  parameter int REG_EVERY = 1
) (
  input logic                clk,
  input logic                rst,
  prefix_adder_pipe_if.slave bus
);

  localparam int LOG = $clog2(N);
  localparam int PB  = pipe_latency(N, REG_EVERY) - 2;
  localparam int LB  = PB - 1;

  if (N < 2) begin : g_bad_n
    $error("prefix_adder_pipe: N must be >= 2");
  end
  if (REG_EVERY < 1) begin : g_bad_reg_every
    $error("prefix_adder_pipe: REG_EVERY must be >= 1");
  end
  if (!(TOPO == int'(TOPO_KS) || TOPO == int'(TOPO_SK))) begin : g_bad_topo
    $error("prefix_adder_pipe: TOPO must be 0 (Kogge-Stone) or 1 (Sklansky)");
  end

  // The whole pipe advances together; it freezes only when a result is blocked.
  logic         w_en;
  logic         r_out_v;
  assign w_en         = !(r_out_v && !bus.out_ready);
  assign bus.in_ready = w_en;

  // Input capture stage.
  logic         r_in_v;
  logic [N-1:0] r_in_a;
  logic [N-1:0] r_in_b;
  logic         r_in_cin;
  logic         r_in_sub;

  // Input valid bit: cleared by reset, follows in_valid while the pipe moves.
  always_ff @(posedge clk) begin
    if (rst) r_in_v <= 1'b0;
    else if (w_en) r_in_v <= bus.in_valid;
  end

  // Input operands: captured whenever the pipe moves.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_in_a   <= bus.a;
      r_in_b   <= bus.b;
      r_in_cin <= bus.cin;
      r_in_sub <= bus.sub;
    end
  end

  // Stage 0: per-bit generate/propagate with B inverted for subtraction.
  logic [N-1:0] w_beff;
  gp_t  [N-1:0] w_s0_gp;
  gp_t  [N-1:0] r_s0_gp;
  logic         r_s0_c0;
  logic         r_s0_v;

  // Bitwise g/p from the captured operands.
  always_comb begin
    w_beff = r_in_sub ? ~r_in_b : r_in_b;
    for (int i = 0; i < N; i++) begin
      w_s0_gp[i].g = r_in_a[i] & w_beff[i];
      w_s0_gp[i].p = r_in_a[i] ^ w_beff[i];
    end
  end

  // Stage 0 valid bit.
  always_ff @(posedge clk) begin
    if (rst) r_s0_v <= 1'b0;
    else if (w_en) r_s0_v <= r_in_v;
  end

  // Stage 0 data; subtract turns the carry-in into an inverted borrow.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s0_gp <= w_s0_gp;
      r_s0_c0 <= r_in_cin ^ r_in_sub;
    end
  end

  // Prefix tree with register banks between groups of levels.
  gp_t  [N-1:0] w_lvl0;
  logic [N-1:0] w_s0_p;
  gp_t  [N-1:0] w_lvl     [1:LOG];
  gp_t  [N-1:0] w_src     [1:LOG];
  gp_t  [N-1:0] w_bank_in [PB];
  gp_t  [N-1:0] r_bk_gp   [PB];
  logic [N-1:0] r_bk_p    [PB];
  logic         r_bk_c0   [PB];
  logic         r_bk_v    [PB];

  // Fold the carry-in in as bit -1 and keep the raw bit propagates for the sum.
  always_comb begin
    w_lvl0      = r_s0_gp;
    w_lvl0[0].g = r_s0_gp[0].g | (r_s0_gp[0].p & r_s0_c0);
    for (int i = 0; i < N; i++) w_s0_p[i] = r_s0_gp[i].p;
  end

  for (genvar k = 1; k <= LOG; k++) begin : g_lvl
    if (k == 1) begin : g_from_s0
      assign w_src[k] = w_lvl0;
    end else if (((k - 1) % REG_EVERY) == 0) begin : g_from_bank
      assign w_src[k] = r_bk_gp[(k - 1) / REG_EVERY - 1];
    end else begin : g_from_comb
      assign w_src[k] = w_lvl[k - 1];
    end
    prefix_level #(
      .N    (N),
      .LEVEL(k),
      .TOPO (TOPO)
    ) u_level (
      .i_gp(w_src[k]),
      .o_gp(w_lvl[k])
    );
  end

  for (genvar bk = 0; bk < PB; bk++) begin : g_bank
    localparam int LV = ((bk + 1) * REG_EVERY > LOG) ? LOG : (bk + 1) * REG_EVERY;
    assign w_bank_in[bk] = w_lvl[LV];
  end

  // Bank valid bits shift along with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < PB; j++) r_bk_v[j] <= 1'b0;
    end else if (w_en) begin
      r_bk_v[0] <= r_s0_v;
      for (int j = 1; j < PB; j++) r_bk_v[j] <= r_bk_v[j - 1];
    end
  end

  // Bank data: prefix results plus the raw propagates and carry-in riding alongside.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_bk_p[0]  <= w_s0_p;
      r_bk_c0[0] <= r_s0_c0;
      for (int j = 1; j < PB; j++) begin
        r_bk_p[j]  <= r_bk_p[j - 1];
        r_bk_c0[j] <= r_bk_c0[j - 1];
      end
      for (int j = 0; j < PB; j++) r_bk_gp[j] <= w_bank_in[j];
    end
  end

  // Final stage: carries are the group generates shifted up one bit.
  logic [N-1:0] w_g_all;
  logic [N-1:0] w_unused_p;
  logic [N-1:0] w_carry;
  logic [N-1:0] w_sum;
  logic         w_cout;
  logic         w_ovf;

  // Sum, carry-out and signed overflow from the completed prefix.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_g_all[i]    = r_bk_gp[LB][i].g;
      w_unused_p[i] = r_bk_gp[LB][i].p;
    end
    w_carry = {w_g_all[N-2:0], r_bk_c0[LB]};
    w_sum   = r_bk_p[LB] ^ w_carry;
    w_cout  = w_g_all[N-1];
    w_ovf   = w_carry[N-1] ^ w_cout;
  end

  logic [N-1:0] r_sum;
  logic         r_cout;
  logic         r_ovf;

  // Output register: holds the last result across bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_v <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_en) begin
      r_out_v <= r_bk_v[LB];
      if (r_bk_v[LB]) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.out_valid = r_out_v;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed table at N=16, stall/reset sequences, and a
// randomized parameter sweep against an arithmetic reference.
module tb_prefix_adder_pipe;

  localparam int N           = 16;
  localparam int LAT16       = 6;
  localparam int NSWEEP      = 24;
  localparam int SWEEP_BEATS = 1000;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic sw_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   sweep_done = 0;

  // Clock
  always #5 clk = ~clk;

  prefix_adder_pipe_if #(.N(N)) bus ();
  prefix_adder_pipe #(.N(N), .TOPO(0), .REG_EVERY(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  // Reference: plain (n+1)-bit arithmetic; result packed as {ovf, cout, sum}.
  function automatic logic [65:0] ref_add(input int n, input logic [63:0] a,
                                          input logic [63:0] b, input logic c,
                                          input logic s);
    logic [64:0] mask;
    logic [64:0] be;
    logic [64:0] full;
    logic        co;
    logic        ov;
    mask = (65'd1 << n) - 65'd1;
    be   = s ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    full = {1'b0, a} + be + 65'(c ^ s);
    co   = full[n];
    ov   = (a[n-1] == be[n-1]) && (full[n-1] != a[n-1]);
    return 66'(full & mask) | (66'(co) << n) | (66'(ov) << (n + 1));
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [65:0] dut_result();
    return 66'({bus.ovf, bus.cout, bus.sum});
  endfunction

  // Single beat on an empty pipe: checks latency and result.
  task automatic run_vec(input int idx);
    int cyc;
    @(negedge clk);
    bus.a         = vecs[idx].a;
    bus.b         = vecs[idx].b;
    bus.cin       = vecs[idx].cin;
    bus.sub       = vecs[idx].sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check($sformatf("vec%0d_latency", idx), 66'(cyc), 66'(LAT16));
    check($sformatf("vec%0d_result", idx), dut_result(),
          66'({vecs[idx].ovf, vecs[idx].cout, vecs[idx].sum}));
    @(posedge clk);
    #1;
  endtask

  // 20 back-to-back beats with out_ready low for three cycles mid-stream.
  task automatic stream_test();
    logic [65:0] exp_q[$];
    logic [65:0] stall_val;
    int sent;
    int got;
    int cyc;
    int extra;
    logic pend;
    sent = 0; got = 0; cyc = 0; extra = 0; pend = 1'b0; stall_val = '0;
    while (got < 20 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = !(cyc >= 10 && cyc <= 12);
      if (!pend) begin
        if (sent < 20) begin
          bus.a        = 16'($urandom());
          bus.b        = 16'($urandom());
          bus.cin      = 1'($urandom_range(0, 1));
          bus.sub      = 1'($urandom_range(0, 1));
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      #1;
      if (cyc == 10) begin
        stall_val = dut_result();
        check("stall_out_valid", 66'(bus.out_valid), 66'(1));
      end
      if (cyc >= 10 && cyc <= 12) check("stall_in_ready", 66'(bus.in_ready), 66'(0));
      if (cyc >= 11 && cyc <= 13) check("stall_stable", dut_result(), stall_val);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("stream_spurious", 66'(bus.out_valid), 66'(0));
        else check($sformatf("stream_beat%0d", got), dut_result(), exp_q.pop_front());
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_add(N, 64'(bus.a), 64'(bus.b), bus.cin, bus.sub));
        sent++;
        pend = 1'b0;
      end else begin
        pend = bus.in_valid;
      end
    end
    check("stream_count", 66'(got), 66'(20));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) extra++;
    end
    check("stream_extra_beats", 66'(extra), 66'(0));
  endtask

  // Reset with four beats in flight, then one fresh beat.
  task automatic reset_test();
    int outs;
    outs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.a         = 16'h1000 + 16'(i);
      bus.b         = 16'h0101;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 66'(bus.out_valid), 66'(0));
    check("midrst_outputs", dut_result(), 66'(0));
    @(negedge clk);
    bus.a        = 16'hFFFF;
    bus.b        = 16'hFFFF;
    bus.in_valid = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.a        = 16'h1234;
    bus.b        = 16'h1111;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        outs++;
        check("post_rst_result", dut_result(), 66'({1'b0, 1'b0, 16'h2345}));
      end
    end
    check("post_rst_beat_count", 66'(outs), 66'(1));
  endtask

  // Main sequence
  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 66'(bus.out_valid), 66'(0));
    check("reset_outputs", dut_result(), 66'(0));
    @(negedge clk);
    rst    = 1'b0;
    sw_rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i);
    stream_test();
    reset_test();

    begin
      int guard;
      guard = 0;
      while (sweep_done < NSWEEP && guard < 50000) begin
        @(negedge clk);
        guard++;
      end
      check("sweep_completed", 66'(sweep_done), 66'(NSWEEP));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Parameter sweep: one instance per configuration, random traffic and random out_ready.
  for (genvar ni = 0; ni < 4; ni++) begin : g_n
    for (genvar ti = 0; ti < 2; ti++) begin : g_t
      for (genvar ri = 0; ri < 3; ri++) begin : g_r
        localparam int NW  = 8 << ni;
        localparam int RE  = 1 << ri;
        localparam int LAT = 2 + ($clog2(NW) + RE - 1) / RE;

        prefix_adder_pipe_if #(.N(NW)) sbus ();
        prefix_adder_pipe #(.N(NW), .TOPO(ti), .REG_EVERY(RE)) u_dut (
          .clk(clk),
          .rst(sw_rst),
          .bus(sbus)
        );

        initial begin : sweep_proc
          logic [65:0] exp_q[$];
          logic [65:0] exp_v;
          logic [63:0] ra;
          logic [63:0] rb;
          int sent;
          int got;
          int guard;
          int cyc;
          logic pend;
          string tag;
          tag   = $sformatf("sweep_n%0d_t%0d_r%0d", NW, ti, RE);
          sent  = 0;
          got   = 0;
          guard = 0;
          pend  = 1'b0;
          sbus.in_valid  = 1'b0;
          sbus.a         = '0;
          sbus.b         = '0;
          sbus.cin       = 1'b0;
          sbus.sub       = 1'b0;
          sbus.out_ready = 1'b1;
          @(negedge clk);
          while (sw_rst) @(negedge clk);

          ra = {$urandom(), $urandom()};
          rb = {$urandom(), $urandom()};
          sbus.a        = ra[NW-1:0];
          sbus.b        = rb[NW-1:0];
          sbus.cin      = 1'($urandom_range(0, 1));
          sbus.sub      = 1'($urandom_range(0, 1));
          sbus.in_valid = 1'b1;
          exp_v = ref_add(NW, 64'(sbus.a), 64'(sbus.b), sbus.cin, sbus.sub);
          @(posedge clk);
          #1;
          sbus.in_valid = 1'b0;
          cyc = 0;
          while (!sbus.out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
          end
          check({tag, "_latency"}, 66'(cyc), 66'(LAT));
          check({tag, "_first"}, 66'({sbus.ovf, sbus.cout, sbus.sum}), exp_v);
          @(posedge clk);
          #1;

          while (got < SWEEP_BEATS && guard < 20000) begin
            @(negedge clk);
            guard++;
            sbus.out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
              if (sent < SWEEP_BEATS && $urandom_range(0, 4) != 0) begin
                ra = {$urandom(), $urandom()};
                rb = {$urandom(), $urandom()};
                case ($urandom_range(0, 7))
                  0: ra = '1;
                  1: rb = '1;
                  2: begin ra = 64'd1 << (NW - 1); rb = ra; end
                  3: begin ra = (64'd1 << (NW - 1)) - 64'd1; rb = 64'd1; end
                  default: ;
                endcase
                sbus.a        = ra[NW-1:0];
                sbus.b        = rb[NW-1:0];
                sbus.cin      = 1'($urandom_range(0, 1));
                sbus.sub      = 1'($urandom_range(0, 1));
                sbus.in_valid = 1'b1;
              end else begin
                sbus.in_valid = 1'b0;
              end
            end
            #1;
            if (sbus.out_valid && sbus.out_ready) begin
              if (exp_q.size() == 0) begin
                check({tag, "_spurious"}, 66'(sbus.out_valid), 66'(0));
              end else begin
                check({tag, "_beat"}, 66'({sbus.ovf, sbus.cout, sbus.sum}), exp_q.pop_front());
              end
              got++;
            end
            if (sbus.in_valid && sbus.in_ready) begin
              exp_q.push_back(ref_add(NW, 64'(sbus.a), 64'(sbus.b), sbus.cin, sbus.sub));
              sent++;
              pend = 1'b0;
            end else begin
              pend = sbus.in_valid;
            end
          end
          check({tag, "_count"}, 66'(got), 66'(SWEEP_BEATS));
          check({tag, "_leftover"}, 66'(exp_q.size()), 66'(0));
          sweep_done++;
        end
      end
    end
  end

endmodule
